dct16_in_loader: RTL and testbench
==================================

Name: dct16_in_loader

Overview:
Serial-to-parallel front end for the 16-point DCT row stage. It accepts one sample per cycle over a valid/ready stream and collects 16 samples into a ping-pong buffer. It presents each complete vector as a flat 16-lane bus with a one-cycle load pulse wired directly to the DCT's x0..x15/load inputs. It also tracks when the matching DCT outputs are valid.

Parameters:
WIDTH_X, 17, sample width and per-lane output width (signed)
LOAD_GAP, 1, minimum cycles between consecutive load pulses (1 = back-to-back allowed)
OUT_LATENCY, 4, cycles from load high to matching DCT outputs valid (>=1)

Ports:
clk  in  1  clock
rst  in  1  reset
s_valid  in  1  input sample valid
s_ready  out  1  loader can accept a sample
s_data  in  WIDTH_X  input sample
s_last  in  1  marks final sample of a vector
x_flat  out  16*WIDTH_X  lane i = bits [i*WIDTH_X +: WIDTH_X], feeds x_i
load  out  1  one-cycle pulse; x_flat valid in same cycle
y_valid  out  1  DCT outputs for a loaded vector valid this cycle
err_short  out  1  sticky: vector closed by s_last before 16 samples

Behaviour:
- Reset: rst, synchronous, active-high; clock clk. In the reset cycle, all state is cleared: both banks empty, write index 0, write bank 0, read bank 0, x_flat=0, load=0, y_valid pipe=0, err_short=0, gap counter=0. Reset mid-frame discards partial and full banks and in-flight y_valid tokens.
- Accept: a sample is accepted in a cycle with s_valid&&s_ready. s_ready = write bank not full. With both banks full, s_ready=0.
- Write side:
  - Lane index wi runs 0..15, and the accepted sample goes to lane wi of the write bank.
  - The bank closes when wi==15 or s_last=1. On close, the bank is marked full, wi returns to 0, and the write bank toggles.
  - Each bank keeps a 16-bit written mask. Unwritten lanes read as 0, so a short vector is zero-padded.
  - s_last on wi<15 sets err_short (sticky until rst). s_last absent at wi==15 closes the bank normally and is not an error.
- Read side:
  - Issue condition: read bank full and gap counter==0.
  - On an edge where the issue condition holds, x_flat is registered from the read bank (masked), load is registered to 1, the bank is freed (full=0, mask=0), the read bank toggles, and the gap counter loads LOAD_GAP-1.
  - Otherwise load is registered to 0 and x_flat holds its last value.
  - The gap counter decrements to 0.
- Latency: last sample accepted in cycle N; bank full in N+1; load=1 and x_flat valid in N+2.
- Simultaneous close and free: write and read of opposite banks happen in the same cycle without conflict.
  - A bank freed at edge E is writable from cycle E+1.
  - If a freed bank is the stalled write bank, s_ready rises in the cycle after the free.
- Throughput: with LOAD_GAP=1 and continuous input, one load every 16 cycles and s_ready stays 1.
- y_valid: a OUT_LATENCY-deep shift register of load. y_valid is high exactly OUT_LATENCY cycles after each load cycle.
- Arithmetic: no arithmetic on data apart from the optional feature. Lanes pass bit-exact.

Optional Feature:
Macro DCT16_IN_LEVEL_SHIFT_EN.
- Defined: each accepted s_data is treated as an unsigned (WIDTH_X-1)-bit pixel in bits [WIDTH_X-2:0], and bit WIDTH_X-1 is ignored. The stored value is pixel - 2^(WIDTH_X-2), a signed WIDTH_X value. Zero-padded lanes remain 0, with no shift applied.
- Undefined: s_data is stored unchanged as signed WIDTH_X. No subtractor is present.

Test Plan:
1. Basic vector: after rst, samples 1..16 on consecutive cycles from cycle 0 -> load=1 in cycle 17 only, lane i=i+1; y_valid=1 in cycle 21 (OUT_LATENCY=4).
2. Back-to-back: 64 continuous samples, value = index -> s_ready never low; loads 16 cycles apart; lanes of load k = 16k..16k+15.
3. Short vector: 5 samples 7,7,7,7,7 with s_last on the 5th -> err_short=1 from next cycle; load lanes 0..4=7, lanes 5..15=0; following full vector is unaffected.
4. Backpressure with LOAD_GAP=40: 48 samples offered continuously -> loads at least 40 cycles apart; s_ready drops after the second bank fills; no sample is lost or duplicated; order is preserved.
5. Reset mid-frame: 10 samples, rst for 1 cycle, then 16 samples 100..115 -> a single load with lanes 100..115; no y_valid from the discarded data; err_short=0.
6. With DCT16_IN_LEVEL_SHIFT_EN, WIDTH_X=9: samples 0, 128, 255 in lanes 0..2 -> lanes = -128, 0, 127.

Source files
------------

// File: rtl/dct16_in_loader.sv
// -----------------------------------------------------------------------------
// dct16_in_loader
//   Serial-to-parallel front end for the 16-point DCT row stage. Samples
//   arrive one per cycle on a valid/ready stream. They are gathered into one
//   of two 16-lane banks (ping-pong). Each complete bank is presented to the
//   DCT as a flat 16-lane bus together with a one-cycle load pulse.
//   y_valid marks the cycle in which the DCT outputs for a loaded vector are
//   valid.
//
// Parameters
//   WIDTH_X     sample / lane width (signed)
//   LOAD_GAP    minimum cycles between load pulses (1 = back-to-back)
//   OUT_LATENCY cycles from load to the matching DCT outputs (>= 1)
//
// Ports
//   clk, rst   clock, synchronous active-high reset
//   s_valid    input sample valid
//   s_ready    loader can accept a sample (write bank not full)
//   s_data     input sample
//   s_last     final sample of a vector (a short vector is zero-padded)
//   x_flat     lane i = x_flat[i*WIDTH_X +: WIDTH_X], registered
//   load       one-cycle pulse, x_flat valid in the same cycle
//   y_valid    load delayed by OUT_LATENCY cycles
//   err_short  sticky: a vector was closed by s_last before 16 samples
//
// Optional feature (macro DCT16_IN_LEVEL_SHIFT_EN)
//   When defined, s_data[WIDTH_X-2:0] is an unsigned pixel. It is stored as
//   pixel - 2^(WIDTH_X-2), and bit WIDTH_X-1 is ignored. Padded lanes stay 0.
// -----------------------------------------------------------------------------
module dct16_in_loader #(
  parameter int WIDTH_X     = 17,
  parameter int LOAD_GAP    = 1,
  parameter int OUT_LATENCY = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [WIDTH_X-1:0]    s_data,
  input  logic                  s_last,
  output logic [16*WIDTH_X-1:0] x_flat,
  output logic                  load,
  output logic                  y_valid,
  output logic                  err_short
);

  localparam int GW = (LOAD_GAP > 1) ? $clog2(LOAD_GAP) : 1;

  typedef logic [WIDTH_X-1:0] sample_t;

  sample_t       mem [2][16];
  logic [15:0]   mask [2];    // lanes written in each bank
  logic [1:0]    full;
  logic          wb;          // write bank
  logic          rb;          // read bank
  logic [3:0]    wi;          // write lane index
  logic [GW-1:0] gap;

  logic    accept;
  logic    close;
  logic    issue;
  sample_t wdata;

  // Write and read only ever touch opposite banks. Accept needs the write
  // bank not full. Issue needs the read bank full.
  assign s_ready = ~full[wb];
  assign accept  = s_valid & s_ready;
  assign close   = accept & ((wi == 4'd15) | s_last);
  assign issue   = full[rb] & (gap == '0);

`ifdef DCT16_IN_LEVEL_SHIFT_EN
  localparam sample_t OFFSET = sample_t'(1) << (WIDTH_X - 2);
  assign wdata = sample_t'({1'b0, s_data[WIDTH_X-2:0]}) - OFFSET;
`else
  assign wdata = s_data;
`endif

  // NOTE: the sample storage has no reset. Stale contents are harmless
  // because every read is gated by the written mask, and the mask is reset.
  always_ff @(posedge clk) begin
    if (accept) mem[wb][wi] <= wdata;
  end

  // NOTE: all sequential state uses non-blocking assignments. Every read in
  // this block therefore sees the value from before the edge. This is what
  // lets close and free of opposite banks happen in one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      full      <= '0;
      mask[0]   <= '0;
      mask[1]   <= '0;
      wb        <= 1'b0;
      rb        <= 1'b0;
      wi        <= '0;
      gap       <= '0;
      x_flat    <= '0;
      load      <= 1'b0;
      err_short <= 1'b0;
    end else begin
      load <= issue;

      if (accept) begin
        mask[wb][wi] <= 1'b1;
        if (s_last && (wi != 4'd15)) err_short <= 1'b1;
        if (close) begin
          full[wb] <= 1'b1;
          wi       <= '0;
          wb       <= ~wb;
        end else begin
          wi <= wi + 4'd1;
        end
      end

      if (issue) begin
        for (int i = 0; i < 16; i++)
          x_flat[i*WIDTH_X +: WIDTH_X] <= mask[rb][i] ? mem[rb][i] : '0;
        full[rb] <= 1'b0;
        mask[rb] <= '0;
        rb       <= ~rb;
        gap      <= GW'(LOAD_GAP - 1);
      end else if (gap != '0) begin
        gap <= gap - GW'(1);
      end
    end
  end

  // Delay line for load. Its tap marks when the DCT outputs are valid.
  generate
    if (OUT_LATENCY == 1) begin : g_lat1
      always_ff @(posedge clk) begin
        if (rst) y_valid <= 1'b0;
        else     y_valid <= load;
      end
    end else begin : g_latn
      logic [OUT_LATENCY-1:0] pipe;
      always_ff @(posedge clk) begin
        if (rst) pipe <= '0;
        else     pipe <= {pipe[OUT_LATENCY-2:0], load};
      end
      assign y_valid = pipe[OUT_LATENCY-1];
    end
  endgenerate

endmodule

// File: tb/tb_dct16_in_loader.sv
// -----------------------------------------------------------------------------
// tb_dct16_in_loader
//   Instance A is the default build (LOAD_GAP=1). Instance B uses LOAD_GAP=40
//   to exercise backpressure. Expected vectors come from a chunking model:
//   accepted samples are grouped into 16-lane vectors, closed at 16 samples
//   or at s_last, and zero-padded.
// -----------------------------------------------------------------------------
module tb_dct16_in_loader;

  localparam int W     = 17;
  localparam int LAT   = 4;
  localparam int GAP_B = 40;
  localparam int VW    = 16 * W;

  typedef logic [VW-1:0] vec_t;

  logic         clk = 1'b0;
  logic         rst = 1'b1;

  logic         a_valid = 1'b0, a_last = 1'b0;
  logic [W-1:0] a_data  = '0;
  logic         a_ready, a_load, a_yv, a_err;
  vec_t         a_x;

  logic         b_valid = 1'b0, b_last = 1'b0;
  logic [W-1:0] b_data  = '0;
  logic         b_ready, b_load, b_yv, b_err;
  vec_t         b_x;

  dct16_in_loader #(.WIDTH_X(W), .LOAD_GAP(1), .OUT_LATENCY(LAT)) dut_a (
    .clk(clk), .rst(rst), .s_valid(a_valid), .s_ready(a_ready),
    .s_data(a_data), .s_last(a_last), .x_flat(a_x), .load(a_load),
    .y_valid(a_yv), .err_short(a_err)
  );

  dct16_in_loader #(.WIDTH_X(W), .LOAD_GAP(GAP_B), .OUT_LATENCY(LAT)) dut_b (
    .clk(clk), .rst(rst), .s_valid(b_valid), .s_ready(b_ready),
    .s_data(b_data), .s_last(b_last), .x_flat(b_x), .load(b_load),
    .y_valid(b_yv), .err_short(b_err)
  );

  always #5 clk = ~clk;

  int tick = 0;
  always @(posedge clk) tick <= tick + 1;

  // ---------------- observation ----------------
  vec_t a_obs[$], b_obs[$];
  int   a_ltick[$], b_ltick[$], a_ytick[$];
  bit   a_ready_low, b_ready_low;

  always @(negedge clk) begin
    if (!rst) begin
      if (a_load) begin a_obs.push_back(a_x); a_ltick.push_back(tick); end
      if (b_load) begin b_obs.push_back(b_x); b_ltick.push_back(tick); end
      if (a_yv) a_ytick.push_back(tick);
      if (!a_ready) a_ready_low = 1'b1;
      if (!b_ready) b_ready_low = 1'b1;
    end
  end

  // ---------------- reference model ----------------
  vec_t exp_a[$], exp_b[$];
  vec_t cur [2];
  int   idx [2];
  bit   err_exp [2];

  function automatic logic [W-1:0] stored(input logic [W-1:0] d);
`ifdef DCT16_IN_LEVEL_SHIFT_EN
    int p;
    p = int'(d[W-2:0]) - (1 << (W - 2));
    return W'(p);
`else
    return d;
`endif
  endfunction

  task automatic model_accept(input bit which, input logic [W-1:0] d, input bit last);
    int k;
    k = which ? 1 : 0;
    cur[k][idx[k]*W +: W] = stored(d);
    if (last && idx[k] < 15) err_exp[k] = 1'b1;
    if (idx[k] == 15 || last) begin
      if (which) exp_b.push_back(cur[k]);
      else       exp_a.push_back(cur[k]);
      cur[k] = '0;
      idx[k] = 0;
    end else begin
      idx[k]++;
    end
  endtask

  // ---------------- checking ----------------
  int tests = 0;
  int fails = 0;
  int t0    = 0;

  task automatic chk(input string tag, input vec_t obs, input vec_t exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic vec_t lane(input vec_t v, input int i);
    return vec_t'(v[i*W +: W]);
  endfunction

  // ---------------- stimulus helpers ----------------
  task automatic idle(input int n);
    a_valid = 1'b0; a_last = 1'b0;
    b_valid = 1'b0; b_last = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    a_valid = 1'b0; a_last = 1'b0;
    b_valid = 1'b0; b_last = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    t0 = tick;
    a_obs.delete(); b_obs.delete();
    a_ltick.delete(); b_ltick.delete(); a_ytick.delete();
    a_ready_low = 1'b0; b_ready_low = 1'b0;
    exp_a.delete(); exp_b.delete();
    for (int k = 0; k < 2; k++) begin
      cur[k] = '0; idx[k] = 0; err_exp[k] = 1'b0;
    end
  endtask

  // Holds the sample until it is accepted. Leaves valid high afterwards so
  // consecutive calls stream one sample per cycle.
  task automatic send(input bit which, input logic [W-1:0] d, input bit last);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    if (which) begin b_valid = 1'b1; b_data = d; b_last = last; end
    else       begin a_valid = 1'b1; a_data = d; a_last = last; end
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = which ? b_ready : a_ready;
      @(posedge clk); #1;
      n++;
    end
    chk("accept", vec_t'(acc), vec_t'(1));
    if (acc) model_accept(which, d, last);
  endtask

  task automatic wait_drain(input bit which, input int n);
    int k;
    k = 0;
    idle(0);
    while ((which ? b_obs.size() : a_obs.size()) < n && k < 400) begin
      @(posedge clk); #1;
      k++;
    end
    idle(LAT + 2);
    chk("load_count", vec_t'(which ? b_obs.size() : a_obs.size()), vec_t'(n));
  endtask

  task automatic cmp_vectors(input bit which, input string tag);
    if (which) begin
      for (int i = 0; i < exp_b.size() && i < b_obs.size(); i++) chk(tag, b_obs[i], exp_b[i]);
    end else begin
      for (int i = 0; i < exp_a.size() && i < a_obs.size(); i++) chk(tag, a_obs[i], exp_a[i]);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("rst_load", vec_t'(a_load), '0);
    chk("rst_yv", vec_t'(a_yv), '0);
    chk("rst_err", vec_t'(a_err), '0);
    chk("rst_x", a_x, '0);
    chk("rst_ready", vec_t'(a_ready), vec_t'(1));

    // 1: basic vector 1..16 from cycle 0
    do_reset();
    for (int i = 1; i <= 16; i++) send(0, W'(i), 1'b0);
    wait_drain(0, 1);
    cmp_vectors(0, "t1_vec");
    chk("t1_lane0", lane(a_obs[0], 0), vec_t'(1));
    chk("t1_lane15", lane(a_obs[0], 15), vec_t'(16));
    chk("t1_load_cycle", vec_t'(a_ltick[0] - t0), vec_t'(17));
    chk("t1_yv_count", vec_t'(a_ytick.size()), vec_t'(1));
    chk("t1_yv_cycle", vec_t'(a_ytick[0] - t0), vec_t'(17 + LAT));

    // 2: back-to-back, 64 samples
    do_reset();
    for (int i = 0; i < 64; i++) send(0, W'(i), 1'b0);
    wait_drain(0, 4);
    chk("t2_ready_low", vec_t'(a_ready_low), '0);
    for (int k = 1; k < a_ltick.size(); k++)
      chk("t2_spacing", vec_t'(a_ltick[k] - a_ltick[k-1]), vec_t'(16));
    cmp_vectors(0, "t2_vec");
    chk("t2_lane_k3", lane(a_obs[3], 5), vec_t'(53));

    // 3: short vector followed by a full vector
    do_reset();
    for (int i = 0; i < 4; i++) send(0, W'(7), 1'b0);
    chk("t3_err_before", vec_t'(a_err), '0);
    send(0, W'(7), 1'b1);
    chk("t3_err_after", vec_t'(a_err), vec_t'(1));
    for (int i = 0; i < 16; i++) send(0, W'(200 + i), 1'b0);
    wait_drain(0, 2);
    cmp_vectors(0, "t3_vec");
    chk("t3_lane4", lane(a_obs[0], 4), vec_t'(7));
    chk("t3_lane5", lane(a_obs[0], 5), '0);
    chk("t3_err_sticky", vec_t'(a_err), vec_t'(1));

    // Reset clears err_short and x_flat
    do_reset();
    @(negedge clk);
    chk("rst2_err", vec_t'(a_err), '0);
    chk("rst2_x", a_x, '0);
    chk("rst2_ready", vec_t'(a_ready), vec_t'(1));
    @(posedge clk); #1;

    // 5: reset mid-frame
    do_reset();
    for (int i = 0; i < 10; i++) send(0, W'(50 + i), 1'b0);
    do_reset();
    for (int i = 0; i < 16; i++) send(0, W'(100 + i), 1'b0);
    wait_drain(0, 1);
    cmp_vectors(0, "t5_vec");
    chk("t5_lane0", lane(a_obs[0], 0), vec_t'(100));
    chk("t5_yv_count", vec_t'(a_ytick.size()), vec_t'(1));
    chk("t5_err", vec_t'(a_err), '0);

    // Random stream on A, with idle gaps and random s_last
    do_reset();
    for (int i = 0; i < 160; i++) begin
      if ($urandom_range(3) == 0) idle($urandom_range(3, 1));
      send(0, W'($urandom), $urandom_range(7) == 0);
    end
    wait_drain(0, exp_a.size());
    cmp_vectors(0, "rnd_a_vec");
    chk("rnd_a_err", vec_t'(a_err), vec_t'(err_exp[0]));
    chk("rnd_a_yv_count", vec_t'(a_ytick.size()), vec_t'(a_ltick.size()));
    for (int k = 0; k < a_ytick.size() && k < a_ltick.size(); k++)
      chk("rnd_a_yv_cycle", vec_t'(a_ytick[k]), vec_t'(a_ltick[k] + LAT));

    // 4: backpressure on B (LOAD_GAP=40)
    do_reset();
    for (int i = 0; i < 48; i++) send(1, W'(i), 1'b0);
    wait_drain(1, 3);
    chk("t4_ready_dropped", vec_t'(b_ready_low), vec_t'(1));
    for (int k = 1; k < b_ltick.size(); k++)
      chk("t4_spacing_ge_gap", vec_t'((b_ltick[k] - b_ltick[k-1]) >= GAP_B), vec_t'(1));
    cmp_vectors(1, "t4_vec");

    // Random stream on B: real stalls with random short vectors
    do_reset();
    for (int i = 0; i < 120; i++) send(1, W'($urandom), $urandom_range(5) == 0);
    wait_drain(1, exp_b.size());
    cmp_vectors(1, "rnd_b_vec");
    chk("rnd_b_err", vec_t'(b_err), vec_t'(err_exp[1]));

`ifdef DCT16_IN_LEVEL_SHIFT_EN
    // 6: level shift of unsigned pixels
    do_reset();
    send(0, W'(0), 1'b0);
    send(0, W'(1 << (W - 2)), 1'b0);
    send(0, W'((1 << (W - 1)) - 1), 1'b1);
    wait_drain(0, 1);
    chk("t6_lane0", lane(a_obs[0], 0), vec_t'(W'(-(1 << (W - 2)))));
    chk("t6_lane1", lane(a_obs[0], 1), '0);
    chk("t6_lane2", lane(a_obs[0], 2), vec_t'((1 << (W - 2)) - 1));
    chk("t6_lane3", lane(a_obs[0], 3), '0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
